// File: rtl/sp_ram_ctrl_if.sv
// sp_ram_ctrl_if: run handshake and read-back bus
// of the RAM bring-up controller.
interface sp_ram_ctrl_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  start;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  done_w;
   logic                  done_r;

   modport master (
      output start,
      input  data_out,
      input  done_w,
      input  done_r
   );

   modport slave (
      input  start,
      output data_out,
      output done_w,
      output done_r
   );
endinterface

// File: rtl/sp_ram_ctrl.sv
// sp_ram_ctrl: fills an internal single-port RAM with
// DATA_BASE + addr, then reads it back in address order.
module sp_ram_ctrl #(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    ADDR_WIDTH = 4,
   parameter logic [DATA_WIDTH-1:0] DATA_BASE  = 16'h0100
) (
   input  logic         clk,
   input  logic         rst,
   sp_ram_ctrl_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST =
      ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      WDONE,
      READ,
      RDONE
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  done_w_q, done_w_d;
   logic                  done_r_q, done_r_d;
   logic                  we, re;
   logic [DATA_WIDTH-1:0] wdata;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   assign wdata = DATA_BASE + DATA_WIDTH'(addr_q);

   // Sequencer: write sweep, pulse, read sweep, pulse.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      we       = 1'b0;
      re       = 1'b0;
      done_w_d = 1'b0;
      done_r_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = WRITE;
               addr_d  = '0;
            end
         end
         WRITE: begin
            we = 1'b1;
            if (addr_q == LAST) begin
               state_d  = WDONE;
               done_w_d = 1'b1;
               addr_d   = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         WDONE: begin
            state_d = READ;
            addr_d  = '0;
         end
         READ: begin
            re = 1'b1;
            if (addr_q == LAST) begin
               state_d  = RDONE;
               done_r_d = 1'b1;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         RDONE: begin
            // done_r cycle: start is deliberately not sampled here
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state, pulses and registered read data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         data_q   <= '0;
         done_w_q <= 1'b0;
         done_r_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         done_w_q <= done_w_d;
         done_r_q <= done_r_d;
         if (re) begin
            data_q <= mem[addr_q];
         end
      end
   end

   // RAM write port; array contents survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr_q] <= wdata;
      end
   end

   assign bus.data_out = data_q;
   assign bus.done_w   = done_w_q;
   assign bus.done_r   = done_r_q;
endmodule

// File: tb/tb_sp_ram_ctrl.sv
// tb_sp_ram_ctrl: directed checks of the write/read sweep
// for the default and a small wrapping configuration.
module tb_sp_ram_ctrl;
   logic clk;
   logic rst;

   int errors;
   int checks;

   logic [15:0] hold0;
   logic [15:0] hold1;

   sp_ram_ctrl_if #(.DATA_WIDTH(16)) bus0 ();
   sp_ram_ctrl_if #(.DATA_WIDTH(16)) bus1 ();

   sp_ram_ctrl #(
      .DATA_WIDTH(16),
      .ADDR_WIDTH(4),
      .DATA_BASE (16'h0100)
   ) dut0 (
      .clk(clk),
      .rst(rst),
      .bus(bus0)
   );

   sp_ram_ctrl #(
      .DATA_WIDTH(16),
      .ADDR_WIDTH(3),
      .DATA_BASE (16'hFFFE)
   ) dut1 (
      .clk(clk),
      .rst(rst),
      .bus(bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic set_start(input int inst, input logic v);
      if (inst == 0) bus0.start = v;
      else           bus1.start = v;
   endtask

   task automatic check_outs(input int inst, input string tag,
                             input logic [15:0] dexp,
                             input logic wexp,
                             input logic rexp);
      logic [15:0] d;
      logic w, r;
      d = (inst == 0) ? bus0.data_out : bus1.data_out;
      w = (inst == 0) ? bus0.done_w   : bus1.done_w;
      r = (inst == 0) ? bus0.done_r   : bus1.done_r;
      check({tag, " data_out"}, 32'(d), 32'(dexp));
      check({tag, " done_w"},   32'(w), 32'(wexp));
      check({tag, " done_r"},   32'(r), 32'(rexp));
   endtask

   // Start pulse sampled at E0, then observe E1..E(2*depth+8).
   task automatic run(input int inst, input int depth,
                      input logic [15:0] base, input bit busy,
                      input string name);
      logic [15:0] hold, dexp;
      hold = (inst == 0) ? hold0 : hold1;
      set_start(inst, 1'b1);
      @(posedge clk);
      #1 set_start(inst, 1'b0);
      for (int n = 1; n <= 2 * depth + 8; n++) begin
         if (busy && (n == 5 || n == 20)) set_start(inst, 1'b1);
         @(posedge clk);
         #1 set_start(inst, 1'b0);
         if (n >= depth + 2 && n <= 2 * depth + 1)
            dexp = base + 16'(n - depth - 2);
         else if (n > 2 * depth + 1)
            dexp = base + 16'(depth - 1);
         else
            dexp = hold;
         check_outs(inst, $sformatf("%s E%0d", name, n), dexp,
                    n == depth, n == 2 * depth + 1);
      end
      if (inst == 0) hold0 = base + 16'(depth - 1);
      else           hold1 = base + 16'(depth - 1);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      hold0 = '0;
      hold1 = '0;
      bus0.start = 1'b0;
      bus1.start = 1'b0;
      rst = 1'b0;

      // reset held with start low
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1 check_outs(0, $sformatf("rst c%0d", i), 16'h0000, 0, 0);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1 check_outs(0, $sformatf("idle c%0d", i), 16'h0000, 0, 0);
         check_outs(1, $sformatf("idle1 c%0d", i), 16'h0000, 0, 0);
      end

      run(0, 16, 16'h0100, 1'b0, "full");
      repeat (2) @(posedge clk);
      #1 check_outs(0, "gap", 16'h010F, 0, 0);

      run(0, 16, 16'h0100, 1'b1, "busy");
      repeat (2) @(posedge clk);
      #1;

      run(0, 16, 16'h0100, 1'b0, "rerun");

      // reset asserted shortly after E20 of a new run
      set_start(0, 1'b1);
      @(posedge clk);
      #1 set_start(0, 1'b0);
      repeat (20) @(posedge clk);
      #2 rst = 1'b0;
      #1 check_outs(0, "async rst", 16'h0000, 0, 0);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1 check_outs(0, $sformatf("abort c%0d", i), 16'h0000, 0, 0);
      end
      @(negedge clk);
      rst = 1'b1;
      hold0 = '0;
      hold1 = '0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1 check_outs(0, $sformatf("post c%0d", i), 16'h0000, 0, 0);
      end
      run(0, 16, 16'h0100, 1'b0, "after rst");

      run(1, 8, 16'hFFFE, 1'b0, "aw3");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
